player_sprite_renderer: RTL and testbench
=========================================

// Module: player_sprite_renderer
// PURPOSE
//  Pixel-pipeline stage directly upstream of the player sprite RAM.
//  - Maps the current beam position (DrawX/DrawY) onto the player sprite box.
//  - Issues the sprite RAM read address and consumes the returned 24-bit RGB.
//  - Emits a keyed pixel to the colour mapper.
//  - Owns the player life state (ALIVE / BLINK / DEAD), which gates visibility.
// PARAMETERS
//  SPRITE_W      48        sprite width, pixels
//  SPRITE_H      30        sprite height, pixels (SPRITE_W*SPRITE_H = 1440 RAM words)
//  TRANSP_KEY    24'hFF00FF  RGB value treated as transparent
//  BLINK_FRAMES  8'd60     frames spent in BLINK before DEAD
// PORTS
//  Clk           in   1   system/pixel clock
//  Reset_n       in   1   synchronous reset, active low
//  frame_start   in   1   1-cycle pulse at start of each frame (vsync edge)
//  DrawX         in   10  current beam column
//  DrawY         in   10  current beam row
//  PlayerX       in   10  sprite top-left column
//  PlayerY       in   10  sprite top-left row
//  hit           in   1   1-cycle pulse: player struck
//  respawn       in   1   1-cycle pulse: request new life
//  read_address  out  19  to sprite RAM read_address
//  sprite_data   in   24  from sprite RAM data_Out (1-cycle RAM read latency)
//  pixel_valid   out  1   1 = pixel_rgb is opaque player pixel for this beam position
//  pixel_rgb     out  24  player colour; 24'h0 when pixel_valid=0
//  player_alive  out  1   1 in ALIVE or BLINK
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge): read_address=0, pixel_valid=0, pixel_rgb=0,
//   state=ALIVE, player_alive=1, blink counter=0, pipeline valid bits=0.
//  Stage 0 (combinational hit test and address):
//   - col = DrawX-PlayerX, row = DrawY-PlayerY, 10-bit unsigned.
//   - in_box = DrawX>=PlayerX && DrawX<PlayerX+SPRITE_W && DrawY>=PlayerY && DrawY<PlayerY+SPRITE_H.
//   - Bounds are compared at 11 bits, so no wrap at the right/bottom screen edge.
//  Stage 1 (posedge N): read_address <= in_box ? row*SPRITE_W+col (zero-extended to 19b) : 0;
//   v1 <= in_box & visible.
//  Stage 2 (posedge N+2): pixel_valid <= v2 && sprite_data!=TRANSP_KEY; pixel_rgb <= that ? sprite_data : 0.
//   v2 is v1 delayed one cycle to align with the RAM latency.
//  Latency: DrawX/DrawY sampled at edge N -> pixel_valid/pixel_rgb updated at edge N+2. Fully pipelined, one pixel per clock.
//  Life FSM:
//   ALIVE: hit -> BLINK, cnt <= BLINK_FRAMES.
//   BLINK: on frame_start, cnt <= cnt-1. frame_start while cnt==1 -> DEAD, cnt <= 0.
//   DEAD: respawn -> ALIVE.
//   - hit is ignored in BLINK and DEAD; respawn is ignored in ALIVE and BLINK.
//   - hit and respawn in the same cycle: the transition legal for the current state is taken.
//   visible = ALIVE | (BLINK & cnt[2]), so the sprite toggles every 4 frames. DEAD -> visible=0.
//  visible is sampled at stage 1; a state change mid-line affects pixels from the next stage-1 sample on.
//  Reset mid-frame flushes the pipeline: the first two post-reset pixels are invalid.
// CONFIGURATION
//  PLAYER_HFLIP_EN defined:
//   - Adds input flip_h (1b), registered on frame_start, so there is no mid-frame tearing.
//   - When the latched flip is 1, col_eff = SPRITE_W-1-col in the address equation.
//  PLAYER_HFLIP_EN undefined: no flip_h port; col_eff = col.
// TESTING
//  1. PlayerX=100, PlayerY=400, DrawX=100, DrawY=400 -> read_address=0 at edge N; DrawX=147, DrawY=429 -> 1439.
//  2. RAM model returns 24'h00FF00 for an in-box pixel -> pixel_valid=1, pixel_rgb=24'h00FF00 exactly 2 edges after DrawX.
//     Returns 24'hFF00FF -> pixel_valid=0, pixel_rgb=0.
//  3. DrawX=99 or 148 (PlayerX=100) -> pixel_valid=0, read_address=0. PlayerX=620, DrawX=639 -> in box, address=19.
//  4. hit in ALIVE -> BLINK, player_alive=1. 60 frame_start pulses -> DEAD, player_alive=0, no valid pixels.
//     respawn -> ALIVE. hit during BLINK leaves cnt unchanged.
//  5. Reset_n=0 for 1 cycle while in BLINK mid-line -> ALIVE, outputs 0, first 2 pixels after release invalid.
//  6. [PLAYER_HFLIP_EN] flip_h=1 latched at frame_start, DrawX=PlayerX, DrawY=PlayerY -> read_address=47.

Source files
------------

// File: rtl/player_sprite_renderer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | player_sprite_renderer: beam hit test, sprite RAM addressing, colour key,   |
// | player life FSM. Optional horizontal mirror via macro PLAYER_HFLIP_EN.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module player_sprite_renderer #(
    parameter int          SPRITE_W     = 48,
    parameter int          SPRITE_H     = 30,
    parameter logic [23:0] TRANSP_KEY   = 24'hFF00FF,
    parameter logic [7:0]  BLINK_FRAMES = 8'd60
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  PlayerX,
    input  logic [9:0]  PlayerY,
    input  logic        hit,
    input  logic        respawn,
`ifdef PLAYER_HFLIP_EN
    input  logic        flip_h,
`endif
    output logic [18:0] read_address,
    input  logic [23:0] sprite_data,
    output logic        pixel_valid,
    output logic [23:0] pixel_rgb,
    output logic        player_alive
);

    localparam logic [18:0] W_19 = 19'(SPRITE_W);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        BLINK = 2'd1,
        DEAD  = 2'd2
    } life_t;

    life_t       state;
    logic [7:0]  cnt;
    logic        visible;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [9:0]  col_eff;
    logic        in_box;
    logic        v1;
    logic        v2;
    logic        opaque;

    assign col = DrawX - PlayerX;
    assign row = DrawY - PlayerY;

    // Bounds widened to 11 bits so a box at the screen edge never wraps to 0.
    assign in_box = ({1'b0, DrawX} >= {1'b0, PlayerX})
                 && ({1'b0, DrawX} <  ({1'b0, PlayerX} + 11'(SPRITE_W)))
                 && ({1'b0, DrawY} >= {1'b0, PlayerY})
                 && ({1'b0, DrawY} <  ({1'b0, PlayerY} + 11'(SPRITE_H)));

`ifdef PLAYER_HFLIP_EN
    logic flip_q;

    // Latched once per frame so the mirror never changes mid-frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            flip_q <= 1'b0;
        end else if (frame_start) begin
            flip_q <= flip_h;
        end
    end

    assign col_eff = flip_q ? (10'(SPRITE_W - 1) - col) : col;
`else
    assign col_eff = col;
`endif

    assign visible = (state == ALIVE) || ((state == BLINK) && cnt[2]);
    assign opaque  = v2 && (sprite_data != TRANSP_KEY);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            read_address <= 19'd0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            pixel_valid  <= 1'b0;
            pixel_rgb    <= 24'd0;
        end else begin
            read_address <= in_box ? ({9'd0, row} * W_19 + {9'd0, col_eff}) : 19'd0;
            v1           <= in_box && visible;
            v2           <= v1;
            pixel_valid  <= opaque;
            pixel_rgb    <= opaque ? sprite_data : 24'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= ALIVE;
            cnt          <= 8'd0;
            player_alive <= 1'b1;
        end else begin
            case (state)
                ALIVE: begin
                    if (hit) begin
                        state <= BLINK;
                        cnt   <= BLINK_FRAMES;
                    end
                end
                BLINK: begin
                    if (frame_start) begin
                        if (cnt == 8'd1) begin
                            state        <= DEAD;
                            cnt          <= 8'd0;
                            player_alive <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                DEAD: begin
                    if (respawn) begin
                        state        <= ALIVE;
                        player_alive <= 1'b1;
                    end
                end
                default: begin
                    state        <= ALIVE;
                    cnt          <= 8'd0;
                    player_alive <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_sprite_renderer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_player_sprite_renderer: randomized bench with a frame-level player model |
// | and a sprite RAM model. Revision: 1.0                                       |
// +-----------------------------------------------------------------------------+
module tb_player_sprite_renderer;

    localparam int          W    = 48;
    localparam int          H    = 30;
    localparam int          NFR  = 60;
    localparam logic [23:0] KEY  = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  PlayerX = '0;
    logic [9:0]  PlayerY = '0;
    logic        hit = 1'b0;
    logic        respawn = 1'b0;
`ifdef PLAYER_HFLIP_EN
    logic        flip_h = 1'b0;
`endif
    logic [18:0] read_address;
    logic [23:0] sprite_data = '0;
    logic        pixel_valid;
    logic [23:0] pixel_rgb;
    logic        player_alive;

    logic [23:0] mem [0:W*H-1];

    int total = 0;
    int bad   = 0;

    // Model: life as "alive"/"blinking with N frames left"/"dead".
    int m_state = 0;
    int m_left  = 0;
    bit m_flip  = 1'b0;

    typedef struct packed {
        logic        v;
        logic [23:0] rgb;
    } pix_t;
    pix_t q[$];

    player_sprite_renderer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .PlayerX      (PlayerX),
        .PlayerY      (PlayerY),
        .hit          (hit),
        .respawn      (respawn),
`ifdef PLAYER_HFLIP_EN
        .flip_h       (flip_h),
`endif
        .read_address (read_address),
        .sprite_data  (sprite_data),
        .pixel_valid  (pixel_valid),
        .pixel_rgb    (pixel_rgb),
        .player_alive (player_alive)
    );

    always #5 Clk = ~Clk;

    // Sprite RAM with one cycle of read latency.
    always @(posedge Clk)
        sprite_data <= (read_address < 19'(W*H)) ? mem[read_address] : 24'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic fs, input logic h, input logic rsp,
                        input int dx, input int dy, input int px, input int py, input logic fl);
        bit   inb;
        bit   vis;
        int   col;
        int   exp_addr;
        pix_t np;
        pix_t cur;
        @(negedge Clk);
        Reset_n     = rn;
        frame_start = fs;
        hit         = h;
        respawn     = rsp;
        DrawX       = 10'(dx);
        DrawY       = 10'(dy);
        PlayerX     = 10'(px);
        PlayerY     = 10'(py);
`ifdef PLAYER_HFLIP_EN
        flip_h      = fl;
`endif
        if (!rn) begin
            exp_addr = 0;
            cur      = '0;
            m_state  = 0;
            m_left   = 0;
            m_flip   = 1'b0;
            q.delete();
            q.push_back('0);
            q.push_back('0);
        end else begin
            inb      = (dx >= px) && (dx < px + W) && (dy >= py) && (dy < py + H);
            vis      = (m_state == 0) || (m_state == 1 && ((m_left / 4) % 2 == 1));
            col      = m_flip ? (W - 1 - (dx - px)) : (dx - px);
            exp_addr = inb ? (dy - py) * W + col : 0;
            np.v     = inb && vis && (mem[exp_addr] != KEY);
            np.rgb   = np.v ? mem[exp_addr] : 24'h0;
            q.push_back(np);
            cur = q.pop_front();
            if (m_state == 0) begin
                if (h) begin
                    m_state = 1;
                    m_left  = NFR;
                end
            end else if (m_state == 1) begin
                if (fs) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_state = 2;
                end
            end else if (rsp) begin
                m_state = 0;
            end
`ifdef PLAYER_HFLIP_EN
            if (fs) m_flip = fl;
`endif
        end
        @(posedge Clk);
        #1;
        check_val("addr",  32'(read_address), 32'(exp_addr));
        check_val("valid", 32'(pixel_valid),  32'(cur.v));
        check_val("rgb",   32'(pixel_rgb),    32'(cur.rgb));
        check_val("alive", 32'(player_alive), 32'(m_state != 2));
    endtask

    initial begin
        int px;
        int py;
        int dx;
        int dy;
        for (int i = 0; i < W*H; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
        mem[5] = 24'h00FF00;
        mem[6] = KEY;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("reset_addr",  32'(read_address), 32'd0);
        check_val("reset_alive", 32'(player_alive), 32'd1);

        step(1, 0, 0, 0, 100, 400, 100, 400, 0);
        check_val("t1_origin", 32'(read_address), 32'd0);
        step(1, 0, 0, 0, 147, 429, 100, 400, 0);
        check_val("t1_last", 32'(read_address), 32'd1439);
        step(1, 0, 0, 0, 105, 400, 100, 400, 0);
        step(1, 0, 0, 0, 106, 400, 100, 400, 0);
        step(1, 0, 0, 0, 99, 400, 100, 400, 0);
        check_val("t2_green_valid", 32'(pixel_valid), 32'd1);
        check_val("t2_green_rgb",   32'(pixel_rgb),   32'h00FF00);
        step(1, 0, 0, 0, 148, 400, 100, 400, 0);
        check_val("t2_key_valid", 32'(pixel_valid), 32'd0);
        check_val("t3_right_out", 32'(read_address), 32'd0);
        step(1, 0, 0, 0, 639, 0, 620, 0, 0);
        check_val("t3_edge_addr", 32'(read_address), 32'd19);

        step(1, 0, 1, 0, 110, 410, 100, 400, 0);
        step(1, 0, 1, 0, 110, 410, 100, 400, 0);
        for (int i = 0; i < NFR - 1; i++)
            step(1, 1, 0, 0, 100 + (i % W), 405, 100, 400, 0);
        check_val("t4_still_blink", 32'(player_alive), 32'd1);
        step(1, 1, 0, 0, 120, 405, 100, 400, 0);
        check_val("t4_dead", 32'(player_alive), 32'd0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 1, 0, 100 + i, 400, 100, 400, 0);
        step(1, 0, 1, 1, 100, 400, 100, 400, 0);
        check_val("t4_respawn", 32'(player_alive), 32'd1);

        step(1, 0, 1, 0, 110, 410, 100, 400, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 0, 111 + i, 410, 100, 400, 0);
        step(0, 0, 0, 0, 117, 410, 100, 400, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 118 + i, 410, 100, 400, 0);

`ifdef PLAYER_HFLIP_EN
        step(1, 1, 0, 0, 0, 0, 200, 200, 1);
        step(1, 0, 0, 0, 200, 200, 200, 200, 0);
        check_val("t6_flip_addr", 32'(read_address), 32'd47);
        step(1, 1, 0, 0, 0, 0, 200, 200, 0);
`endif

        px = 300;
        py = 200;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                px = $urandom_range(0, 1000);
                py = $urandom_range(0, 1000);
            end
            dx = px + int'($urandom_range(0, 55)) - 4;
            dy = py + int'($urandom_range(0, 37)) - 4;
            if (dx < 0) dx = 0;
            if (dx > 1023) dx = 1023;
            if (dy < 0) dy = 0;
            if (dy > 1023) dy = 1023;
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 20) == 0),
                 dx, dy, px, py, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
